// File: rtl/zeroriscy_register_file_mp.sv
// -----------------------------------------------------------------------------
// zeroriscy_register_file_mp
//
// Multi-port flip-flop register file for the ID stage. It has NUM_READ
// combinational read ports and NUM_WRITE write ports. The second write port
// serves LSU write-back alongside ALU write-back.
//
// A write is captured into a one-cycle staging register and committed to the
// array on the next edge. Reads bypass from the staging register, so a value
// written in cycle N is visible in cycle N+1. x0 always reads as zero.
//
// Optional feature: define ZERORISCY_RF_PARITY_EN to store one even-parity bit
// per word and report per-port read parity errors on rerr_o.
//
// Parameters
//   RV32E       0: 32 words (x0..x31), 1: 16 words (x0..x15)
//   DATA_WIDTH  word width in bits
//   NUM_READ    number of read ports (1..4)
//   NUM_WRITE   number of write ports (1..2); a higher index has higher priority
//
// Ports
//   clk_int      clock, rising edge
//   rst_n        asynchronous active-low reset
//   raddr_i      read addresses, port p at [5p+4:5p]
//   rdata_o      read data, combinational, port p at [DW*p +: DW]
//   waddr_i      write addresses, port w at [5w+4:5w]
//   wdata_i      write data, port w at [DW*w +: DW]
//   we_i         write enables, one per write port
//   waddr_err_o  registered one-cycle pulse: an enabled write hit a
//                nonexistent register (RV32E, address >= 16)
//   rerr_o       per-read-port parity error (0 without ZERORISCY_RF_PARITY_EN)
// -----------------------------------------------------------------------------
module zeroriscy_register_file_mp #(
   parameter int RV32E      = 0,
   parameter int DATA_WIDTH = 32,
   parameter int NUM_READ   = 2,
   parameter int NUM_WRITE  = 2
) (
   input  logic                           clk_int,
   input  logic                           rst_n,
   input  logic [NUM_READ*5-1:0]          raddr_i,
   output logic [NUM_READ*DATA_WIDTH-1:0] rdata_o,
   input  logic [NUM_WRITE*5-1:0]         waddr_i,
   input  logic [NUM_WRITE*DATA_WIDTH-1:0] wdata_i,
   input  logic [NUM_WRITE-1:0]           we_i,
   output logic                           waddr_err_o,
   output logic [NUM_READ-1:0]            rerr_o
);

   localparam int NUM_WORDS = (RV32E != 0) ? 16 : 32;
   localparam int AW        = (RV32E != 0) ? 4 : 5;

   // An address names an existing register when it is below NUM_WORDS.
   function automatic logic addr_legal(input logic [4:0] a);
      return (RV32E == 0) || !a[4];
   endfunction

   // ---------------------------------------------------------------------------
   // Stage 1: write staging
   // ---------------------------------------------------------------------------
   logic [4:0]            w_waddr   [NUM_WRITE];
   logic [DATA_WIDTH-1:0] w_wdata   [NUM_WRITE];
   logic [NUM_WRITE-1:0]  w_wr_ok;
   logic [NUM_WRITE-1:0]  w_wr_bad;

   logic [NUM_WRITE-1:0]  r_we_q;
   logic [4:0]            r_waddr_q [NUM_WRITE];
   logic [DATA_WIDTH-1:0] r_wdata_q [NUM_WRITE];
   logic                  r_waddr_err;

   // NOTE: every output of a combinational block gets a default first, so no
   // path leaves it unassigned and no latch is inferred.
   always_comb begin
      w_wr_ok  = '0;
      w_wr_bad = '0;
      for (int w = 0; w < NUM_WRITE; w++) begin
         w_waddr[w]  = waddr_i[5*w +: 5];
         w_wdata[w]  = wdata_i[DATA_WIDTH*w +: DATA_WIDTH];
         // Writes to x0 are dropped silently; writes past the array are
         // dropped and flagged.
         w_wr_ok[w]  = we_i[w] && (w_waddr[w] != 5'd0) && addr_legal(w_waddr[w]);
         w_wr_bad[w] = we_i[w] && !addr_legal(w_waddr[w]);
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk_int or negedge rst_n) begin
      if (!rst_n) begin
         r_we_q      <= '0;
         r_waddr_err <= 1'b0;
         for (int w = 0; w < NUM_WRITE; w++) begin
            r_waddr_q[w] <= '0;
            r_wdata_q[w] <= '0;
         end
      end else begin
         r_we_q      <= w_wr_ok;
         r_waddr_err <= |w_wr_bad;
         // Address/data only move when the port is enabled; otherwise they
         // hold so the staging register does not toggle on idle cycles.
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (we_i[w]) begin
               r_waddr_q[w] <= w_waddr[w];
               r_wdata_q[w] <= w_wdata[w];
            end
         end
      end
   end

   assign waddr_err_o = r_waddr_err;

   // ---------------------------------------------------------------------------
   // Stage 2: commit into the array
   // ---------------------------------------------------------------------------
   logic [DATA_WIDTH-1:0] r_mem [NUM_WORDS];
`ifdef ZERORISCY_RF_PARITY_EN
   logic                  r_par [NUM_WORDS];
`endif

   // NOTE: the array is a real flop array and is cleared on reset, so a read
   // after reset returns zero rather than stale contents.
   always_ff @(posedge clk_int or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < NUM_WORDS; i++) begin
            r_mem[i] <= '0;
`ifdef ZERORISCY_RF_PARITY_EN
            r_par[i] <= 1'b0;
`endif
         end
      end else begin
         // Word 0 is never written. The inner loop runs in ascending port
         // order, so a higher port staged to the same word overrides a lower one.
         for (int i = 1; i < NUM_WORDS; i++) begin
            for (int w = 0; w < NUM_WRITE; w++) begin
               if (r_we_q[w] && (r_waddr_q[w] == 5'(i))) begin
                  r_mem[i] <= r_wdata_q[w];
`ifdef ZERORISCY_RF_PARITY_EN
                  r_par[i] <= ^r_wdata_q[w];
`endif
               end
            end
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read ports: zero / bypass / array
   // ---------------------------------------------------------------------------
   for (genvar p = 0; p < NUM_READ; p++) begin : g_rd
      logic [4:0]            w_ra;
      logic                  w_ra_ok;
      logic [AW-1:0]         w_idx;
      logic [NUM_WRITE-1:0]  w_hit;
      logic [DATA_WIDTH-1:0] w_data;

      assign w_ra    = raddr_i[5*p +: 5];
      assign w_ra_ok = (w_ra != 5'd0) && addr_legal(w_ra);
      assign w_idx   = w_ra[AW-1:0];

      always_comb begin
         w_hit  = '0;
         w_data = r_mem[w_idx];
         // Ascending scan: the highest staged port that matches wins.
         for (int w = 0; w < NUM_WRITE; w++) begin
            if (r_we_q[w] && (r_waddr_q[w] == w_ra)) begin
               w_hit[w] = 1'b1;
               w_data   = r_wdata_q[w];
            end
         end
      end

      assign rdata_o[DATA_WIDTH*p +: DATA_WIDTH] = w_ra_ok ? w_data : '0;

`ifdef ZERORISCY_RF_PARITY_EN
      // Bypassed data has no stored parity to disagree with, so it never
      // reports an error.
      assign rerr_o[p] = w_ra_ok && !(|w_hit) && ((^r_mem[w_idx]) ^ r_par[w_idx]);
`else
      assign rerr_o[p] = 1'b0;
`endif
   end

endmodule

// File: tb/tb_zeroriscy_register_file_mp.sv
// -----------------------------------------------------------------------------
// tb_zeroriscy_register_file_mp
//
// Drives one RV32I instance and one RV32E instance from the same stimulus and
// compares both against an architectural model: a write becomes the register's
// value at the edge where it is presented, so reads in the cycle of we_i still
// see the old value and reads from the next cycle on see the new one.
// -----------------------------------------------------------------------------
module tb_zeroriscy_register_file_mp;

   logic        clk_int = 1'b0;
   logic        rst_n;
   logic [9:0]  raddr;
   logic [9:0]  waddr;
   logic [63:0] wdata;
   logic [1:0]  we;
   logic [63:0] rdata;
   logic [63:0] rdata_e;
   logic        err;
   logic        err_e;
   logic [1:0]  rerr;
   logic [1:0]  rerr_e;

   int n_checks = 0;
   int n_fail   = 0;

   // Architectural model: m for 32 words, me for the 16-word variant.
   logic [31:0] m  [32];
   logic [31:0] me [32];
   logic        exp_err_e;

   always #5 clk_int = ~clk_int;

   zeroriscy_register_file_mp #(.RV32E(0)) dut (
      .clk_int(clk_int), .rst_n(rst_n),
      .raddr_i(raddr), .rdata_o(rdata),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
      .waddr_err_o(err), .rerr_o(rerr)
   );

   zeroriscy_register_file_mp #(.RV32E(1)) dut_e (
      .clk_int(clk_int), .rst_n(rst_n),
      .raddr_i(raddr), .rdata_o(rdata_e),
      .waddr_i(waddr), .wdata_i(wdata), .we_i(we),
      .waddr_err_o(err_e), .rerr_o(rerr_e)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] exp_rd(input logic [4:0] a, input bit e);
      if (a == 5'd0) return 32'h0;
      if (e) return (a >= 5'd16) ? 32'h0 : me[a];
      return m[a];
   endfunction

   task automatic model_clear();
      for (int i = 0; i < 32; i++) begin
         m[i]  = 32'h0;
         me[i] = 32'h0;
      end
      exp_err_e = 1'b0;
   endtask

   task automatic drive(input logic [1:0] e, input logic [4:0] a0, input logic [31:0] d0,
                        input logic [4:0] a1, input logic [31:0] d1);
      we    = e;
      waddr = {a1, a0};
      wdata = {d1, d0};
   endtask

   task automatic rd(input logic [4:0] r0, input logic [4:0] r1);
      raddr = {r1, r0};
   endtask

   // Advance one clock edge and apply the presented writes to the model.
   task automatic tick();
      logic [4:0] a;
      @(posedge clk_int);
      exp_err_e = 1'b0;
      if (!rst_n) begin
         model_clear();
      end else begin
         for (int w = 0; w < 2; w++) begin
            if (we[w]) begin
               a = waddr[5*w +: 5];
               if (a != 5'd0) m[a] = wdata[32*w +: 32];
               if (a >= 5'd16) exp_err_e = 1'b1;
               else if (a != 5'd0) me[a] = wdata[32*w +: 32];
            end
         end
      end
      #1;
   endtask

   task automatic check_reads(input string tag);
      logic [4:0] a;
      for (int p = 0; p < 2; p++) begin
         a = raddr[5*p +: 5];
         check($sformatf("%s rd%0d x%0d", tag, p, a), rdata[32*p +: 32], exp_rd(a, 1'b0));
         check($sformatf("%s rv32e rd%0d x%0d", tag, p, a), rdata_e[32*p +: 32], exp_rd(a, 1'b1));
      end
      check({tag, " err"}, {31'b0, err}, 32'h0);
      check({tag, " rv32e err"}, {31'b0, err_e}, {31'b0, exp_err_e});
      check({tag, " rerr"}, {28'b0, rerr_e, rerr}, 32'h0);
   endtask

   initial begin
      logic [4:0] last_a;
      rst_n = 1'b0;
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      rd(5'd0, 5'd0);
      model_clear();
      last_a = 5'd1;

      // Reset state
      #12;
      check_reads("reset");
      rd(5'd7, 5'd31);
      #1;
      check_reads("reset");
      check("reset x7", rdata[31:0], 32'h0);
      rst_n = 1'b1;
      tick();

      // Bypass: old value in cycle 0, bypass in cycle 1, array in cycle 2
      drive(2'b01, 5'd5, 32'hDEADBEEF, 5'd0, 32'h0);
      rd(5'd5, 5'd5);
      #1;
      check_reads("byp c0");
      check("byp c0 old", rdata[31:0], 32'h0);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      check_reads("byp c1");
      check("byp c1 bypass", rdata[31:0], 32'hDEADBEEF);
      tick();
      #1;
      check_reads("byp c2");
      check("byp c2 mem", rdata[31:0], 32'hDEADBEEF);

      // Same-address dual write: port 1 wins
      drive(2'b11, 5'd7, 32'h11111111, 5'd7, 32'h22222222);
      rd(5'd7, 5'd7);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      check_reads("conf c1");
      check("conf c1 x7", rdata[63:32], 32'h22222222);
      tick();
      #1;
      check("conf c2 x7", rdata[31:0], 32'h22222222);

      // Distinct-address dual write: both land
      drive(2'b11, 5'd8, 32'h3, 5'd9, 32'h4);
      rd(5'd8, 5'd9);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      check_reads("dual c1");
      check("dual x8", rdata[31:0], 32'h3);
      check("dual x9", rdata[63:32], 32'h4);
      tick();
      #1;
      check_reads("dual c2");

      // Back-to-back writes to the same address
      drive(2'b01, 5'd12, 32'hA0A0A0A0, 5'd0, 32'h0);
      rd(5'd12, 5'd12);
      tick();
      drive(2'b10, 5'd0, 32'h0, 5'd12, 32'hB1B1B1B1);
      #1;
      check("b2b n+1", rdata[31:0], 32'hA0A0A0A0);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      check("b2b n+2", rdata[31:0], 32'hB1B1B1B1);
      tick();

      // x0 write is dropped silently
      drive(2'b11, 5'd0, 32'hFFFFFFFF, 5'd0, 32'hFFFFFFFF);
      rd(5'd0, 5'd0);
      #1;
      check_reads("x0 c0");
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      check_reads("x0 c1");
      check("x0 value", rdata[31:0], 32'h0);
      check("x0 err", {31'b0, err}, 32'h0);
      tick();
      #1;
      check_reads("x0 c2");

      // RV32E illegal address: one-cycle error, no aliasing onto x4
      drive(2'b01, 5'd4, 32'hAAAAAAAA, 5'd0, 32'h0);
      tick();
      drive(2'b01, 5'd20, 32'h5, 5'd0, 32'h0);
      rd(5'd20, 5'd4);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      check_reads("rv32e c1");
      check("rv32e err pulse", {31'b0, err_e}, 32'h1);
      check("rv32e x4 kept", rdata_e[63:32], 32'hAAAAAAAA);
      check("rv32e x20 zero", rdata_e[31:0], 32'h0);
      check("rv32i x20", rdata[31:0], 32'h5);
      tick();
      #1;
      check_reads("rv32e c2");
      check("rv32e err clear", {31'b0, err_e}, 32'h0);

`ifdef ZERORISCY_RF_PARITY_EN
      // Parity: bypass never errors; a flipped stored bit errors on all ports
      drive(2'b01, 5'd3, 32'h1, 5'd0, 32'h0);
      rd(5'd3, 5'd3);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      #1;
      check("par bypass", {30'b0, rerr}, 32'h0);
      tick();
      #1;
      check("par clean", {30'b0, rerr}, 32'h0);
      dut.r_par[3] = ~dut.r_par[3];
      #1;
      check("par flipped", {30'b0, rerr}, 32'h3);
      dut.r_par[3] = ~dut.r_par[3];
      #1;
      check("par restored", {30'b0, rerr}, 32'h0);
`endif

      // Randomised traffic against the model
      for (int c = 0; c < 400; c++) begin
         drive(2'($urandom_range(0, 3)),
               5'($urandom_range(0, 23)), $urandom(),
               5'($urandom_range(0, 23)), $urandom());
         rd(($urandom_range(0, 2) == 0) ? last_a : 5'($urandom_range(0, 31)),
            ($urandom_range(0, 2) == 0) ? last_a : 5'($urandom_range(0, 31)));
         #1;
         check_reads("rand");
         last_a = waddr[4:0];
         tick();
      end

      // Reset mid-operation with both ports staged
      drive(2'b11, 5'd10, 32'h12345678, 5'd11, 32'h9ABCDEF0);
      rd(5'd10, 5'd11);
      tick();
      drive(2'b00, 5'd0, 32'h0, 5'd0, 32'h0);
      rst_n = 1'b0;
      model_clear();
      #1;
      check_reads("mid rst");
      check("mid rst x10", rdata[31:0], 32'h0);
      check("mid rst x11", rdata[63:32], 32'h0);
      tick();
      rst_n = 1'b1;
      rd(5'd5, 5'd10);
      tick();
      #1;
      check_reads("post rst");
      check("post rst x5", rdata[31:0], 32'h0);
      tick();
      #1;
      check("post rst x10", rdata[63:32], 32'h0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/zeroriscy_register_file_mp.md
Name: zeroriscy_register_file_mp

Overview:
- Parametrised multi-port successor to the single-write latch register file.
- Provides NUM_READ combinational read ports and NUM_WRITE write ports into a flip-flop array of 31 (RV32I) or 15 (RV32E) writable words; x0 reads as zero.
- Writes are staged for one cycle, then committed. Reads bypass from the staging stage, so a value written in cycle N is readable in cycle N+1.
- Sits in the ID stage; the extra write port serves LSU write-back alongside ALU write-back.

Parameters:
- RV32E, 0, 1 = 16 words (4-bit address), 0 = 32 words (5-bit address).
- DATA_WIDTH, 32, word width in bits.
- NUM_READ, 2, number of read ports (1..4).
- NUM_WRITE, 2, number of write ports (1..2); a higher port index has higher priority.

Ports:
- clk_int  in  1  clock; all state updates on its rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- raddr_i  in  NUM_READ*5  read addresses; port p occupies bits [5p+4:5p].
- rdata_o  out  NUM_READ*DATA_WIDTH  read data, combinational.
- waddr_i  in  NUM_WRITE*5  write addresses.
- wdata_i  in  NUM_WRITE*DATA_WIDTH  write data.
- we_i  in  NUM_WRITE  write enables.
- waddr_err_o  out  1  registered pulse: an enabled write addressed a nonexistent register.
- rerr_o  out  NUM_READ  parity error per read port; tied 0 when the optional feature is disabled.

Behaviour:
- Reset (async assert, sync-released by the environment):
  - all mem words clear to 0;
  - staging valids we_q[*] clear to 0;
  - waddr_err_o = 0;
  - the parity array clears to 0, which is consistent with even parity on zero data.
- Stage 1 (edge N):
  - for each port w, we_q[w] <= we_i[w] && waddr != 0 && addr legal;
  - waddr_q[w] and wdata_q[w] are captured only when we_i[w] = 1, otherwise they hold.
- Legal address: waddr < NUM_WORDS. With RV32E = 1, addresses 16..31 are illegal. Illegal writes are dropped and set waddr_err_o = 1 for exactly one cycle (cycle N+1).
- Stage 2 (edge N+1): for each w with we_q[w], mem[waddr_q[w]] <= wdata_q[w].
- Commit conflict: if both ports are staged to the same address, port NUM_WRITE-1 wins and the lower port's write is discarded with no error.
- Read, combinational. Priority per read port, highest first:
  1. raddr = 0, or raddr illegal (RV32E and raddr >= 16): return 0.
  2. Staged port NUM_WRITE-1 matches the address: return its wdata_q.
  3. Staged port 0 matches the address: return its wdata_q.
  4. Otherwise return mem[raddr].
- Resulting read latencies:
  - cycle N+1 reads return new data via bypass;
  - cycle N+2 onwards reads return it from mem;
  - a read in cycle N (same cycle as we_i) returns the old value. There is no bypass from unregistered inputs.
- Back-to-back writes to the same address in cycles N and N+1: the commit at N+1 and the restage at N+1 occur together. Reads in N+1 see data N; reads in N+2 see data N+1.
- Reset mid-operation: staged writes are lost and are never committed.
- Write to x0: dropped silently, no error.

Optional Feature:
- Macro: ZERORISCY_RF_PARITY_EN.
- Defined:
  - one even-parity bit per word is stored alongside mem, computed from wdata_q at commit;
  - a bypassed read carries freshly computed parity, so it never errors;
  - rerr_o[p] = 1 when the XOR of mem data and stored parity for the read address = 1; gated to 0 for x0 and illegal addresses;
  - combinational, same cycle as rdata_o.
- Undefined: no parity storage and rerr_o = '0.

Test Plan:
- Reset: assert rst_n = 0 mid-run with we_i = 2'b11 staged → all reads 0, waddr_err_o = 0; after release, mem[5] reads 0.
- Bypass: cycle 0 write x5 = 0xDEADBEEF on port 0; read x5 on port 0 → cycle 0 returns 0x0, cycle 1 0xDEADBEEF (bypass), cycle 2 0xDEADBEEF (mem).
- Dual-write conflict: same cycle, port 0 writes x7 = 0x11111111 and port 1 writes x7 = 0x22222222 → x7 reads 0x22222222 from cycle 1 on; port 0 writing x8 = 0x3 alongside port 1 writing x9 = 0x4 → both land.
- x0: write x0 = 0xFFFFFFFF → x0 reads 0 on all cycles, waddr_err_o stays 0.
- RV32E = 1: write x20 = 0x5 → waddr_err_o = 1 for exactly one cycle; x4 is not modified; reading x20 returns 0.
- Parity (ZERORISCY_RF_PARITY_EN): write x3 = 0x1, then force-flip the stored parity bit via hierarchical deposit → rerr_o[p] = 1 on any port reading x3; rerr_o = 0 for the bypassed read in the cycle after write.
